// File: rtl/lif_neuron4.sv
// ----------------------------------------------------------------------------
// lif_neuron4
//
// Four-input leaky integrate-and-fire neuron. Each cycle the 4-bit weights of
// the active pre-synaptic inputs are summed, the 8-bit membrane potential is
// leaked by v >> LEAK_SHIFT and the sum added (saturating at 255). When the
// new potential reaches THRESHOLD the neuron emits a one-cycle post_spike,
// clears the membrane, spends one FIRE cycle and then REFRACT_CYCLES
// refractory cycles ignoring its inputs. The post_spike feeds the STDP block,
// whose weight updates come back in through weight_in / weight_load.
//
// Parameters:
//   THRESHOLD      firing threshold (fire when next potential >= THRESHOLD)
//   LEAK_SHIFT     leak per cycle is v >> LEAK_SHIFT, legal 1..7
//   REFRACT_CYCLES refractory length in cycles, legal 0..15
//
// Ports:
//   clk           clock, all state changes on the rising edge
//   rst_n         synchronous active-low reset
//   pre_spike     [3:0]  pre-synaptic spikes, level-sampled every edge
//   weight_in     [15:0] packed weights, synapse i = weight_in[4i+3:4i]
//   weight_load   captures weight_in into all four weight registers
//   post_spike    registered one-cycle fire pulse
//   membrane      [7:0]  membrane potential register
//   neuron_state  [1:0]  0 = INTEGRATE, 1 = FIRE, 2 = REFRACT
//   spike_count   [7:0]  saturating count of fired spikes
// ----------------------------------------------------------------------------
module lif_neuron4 #(
    parameter logic [7:0]  THRESHOLD      = 8'd32,
    parameter int unsigned LEAK_SHIFT     = 3,
    parameter int unsigned REFRACT_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  pre_spike,
    input  logic [15:0] weight_in,
    input  logic        weight_load,
    output logic        post_spike,
    output logic [7:0]  membrane,
    output logic [1:0]  neuron_state,
    output logic [7:0]  spike_count
);

    typedef enum logic [1:0] {
        ST_INTEGRATE = 2'd0,
        ST_FIRE      = 2'd1,
        ST_REFRACT   = 2'd2,
        ST_ILLEGAL   = 2'd3
    } state_e;

    // Counter value loaded on leaving FIRE; unused when REFRACT_CYCLES is 0.
    localparam logic [3:0] REFR_LOAD =
        (REFRACT_CYCLES == 0) ? 4'd0 : 4'(REFRACT_CYCLES - 1);

    state_e          state_q, state_d;
    logic [3:0]      refr_cnt_q, refr_cnt_d;
    logic            post_spike_q, post_spike_d;
    logic [7:0]      membrane_q, membrane_d;
    logic [7:0]      spike_count_q, spike_count_d;
    logic [3:0][3:0] w_q, w_d;

    logic [5:0] syn_sum;
    logic [7:0] leaked;
    logic [8:0] v_sum;
    logic [7:0] v_next;

    // ------------------------------------------------------------------
    // Synaptic input and membrane update (always the old weights)
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: blocking assignments here build an accumulation chain inside
        // one combinational evaluation; registers elsewhere use <= only.
        syn_sum = '0;
        for (int i = 0; i < 4; i++) begin
            if (pre_spike[i]) begin
                syn_sum = syn_sum + {2'b00, w_q[i]};
            end
        end
    end

    // Truncating shift: potentials below 2^LEAK_SHIFT do not decay.
    assign leaked = membrane_q - (membrane_q >> LEAK_SHIFT);
    assign v_sum  = {1'b0, leaked} + {3'b000, syn_sum};
    assign v_next = v_sum[8] ? 8'hFF : v_sum[7:0];

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        state_d       = state_q;
        refr_cnt_d    = refr_cnt_q;
        post_spike_d  = 1'b0;
        membrane_d    = membrane_q;
        spike_count_d = spike_count_q;
        w_d           = weight_load ? weight_in : w_q;

        case (state_q)
            ST_INTEGRATE: begin
                if (v_next >= THRESHOLD) begin
                    membrane_d   = 8'd0;
                    post_spike_d = 1'b1;
                    state_d      = ST_FIRE;
                    if (spike_count_q != 8'hFF) begin
                        spike_count_d = spike_count_q + 8'd1;
                    end
                end else begin
                    membrane_d = v_next;
                end
            end
            ST_FIRE: begin
                membrane_d = 8'd0;
                if (REFRACT_CYCLES == 0) begin
                    state_d = ST_INTEGRATE;
                end else begin
                    state_d    = ST_REFRACT;
                    refr_cnt_d = REFR_LOAD;
                end
            end
            ST_REFRACT: begin
                membrane_d = 8'd0;
                if (refr_cnt_q == 4'd0) begin
                    state_d = ST_INTEGRATE;
                end else begin
                    refr_cnt_d = refr_cnt_q - 4'd1;
                end
            end
            default: begin
                // Unreachable encoding: fall back to a clean integrate state.
                state_d    = ST_INTEGRATE;
                membrane_d = 8'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the weight file is only four small flops, so it is reset
            // with everything else and the neuron never sees unknown weights.
            state_q       <= ST_INTEGRATE;
            refr_cnt_q    <= 4'd0;
            post_spike_q  <= 1'b0;
            membrane_q    <= 8'd0;
            spike_count_q <= 8'd0;
            w_q           <= '0;
        end else begin
            state_q       <= state_d;
            refr_cnt_q    <= refr_cnt_d;
            post_spike_q  <= post_spike_d;
            membrane_q    <= membrane_d;
            spike_count_q <= spike_count_d;
            w_q           <= w_d;
        end
    end

    assign post_spike   = post_spike_q;
    assign membrane     = membrane_q;
    assign neuron_state = state_q;
    assign spike_count  = spike_count_q;

endmodule

// File: tb/tb_lif_neuron4.sv
// ----------------------------------------------------------------------------
// tb_lif_neuron4
//
// Directed bench for lif_neuron4. Three instances share one stimulus stream:
// default parameters, REFRACT_CYCLES = 0, and THRESHOLD = 255. Every test
// resets first, so each one checks only the instance it is about.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
// ----------------------------------------------------------------------------
module tb_lif_neuron4;

    logic        clk;
    logic        rst_n;
    logic [3:0]  pre_spike;
    logic [15:0] weight_in;
    logic        weight_load;

    logic       post_def, post_r0, post_t255;
    logic [7:0] mem_def, mem_r0, mem_t255;
    logic [1:0] st_def, st_r0, st_t255;
    logic [7:0] cnt_def, cnt_r0, cnt_t255;

    int total = 0;
    int bad   = 0;

    lif_neuron4 dut_def (
        .clk(clk), .rst_n(rst_n), .pre_spike(pre_spike), .weight_in(weight_in),
        .weight_load(weight_load), .post_spike(post_def), .membrane(mem_def),
        .neuron_state(st_def), .spike_count(cnt_def)
    );

    lif_neuron4 #(.REFRACT_CYCLES(0)) dut_r0 (
        .clk(clk), .rst_n(rst_n), .pre_spike(pre_spike), .weight_in(weight_in),
        .weight_load(weight_load), .post_spike(post_r0), .membrane(mem_r0),
        .neuron_state(st_r0), .spike_count(cnt_r0)
    );

    lif_neuron4 #(.THRESHOLD(8'd255)) dut_t255 (
        .clk(clk), .rst_n(rst_n), .pre_spike(pre_spike), .weight_in(weight_in),
        .weight_load(weight_load), .post_spike(post_t255), .membrane(mem_t255),
        .neuron_state(st_t255), .spike_count(cnt_t255)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; pre_spike = 4'h0; weight_load = 1'b0; weight_in = 16'h0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic load_weights(input logic [15:0] w);
        weight_load = 1'b1; weight_in = w; pre_spike = 4'h0;
        tick();
        weight_load = 1'b0;
    endtask

    // Reset dominates weight_load and spiking inputs.
    task automatic test_reset();
        rst_n = 1'b0; pre_spike = 4'hF; weight_load = 1'b1; weight_in = 16'hFFFF;
        tick();
        tick();
        total++; if (post_def !== 1'b0) begin bad++; $display("FAIL reset_post got=%0d exp=0", post_def); end
        total++; if (mem_def !== 8'd0) begin bad++; $display("FAIL reset_membrane got=%0d exp=0", mem_def); end
        total++; if (cnt_def !== 8'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", cnt_def); end
        total++; if (st_def !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", st_def); end
        rst_n = 1'b1; weight_load = 1'b0; pre_spike = 4'hF;
        tick();
        total++; if (post_def !== 1'b0) begin bad++; $display("FAIL reset_zero_weights_post got=%0d exp=0", post_def); end
        total++; if (mem_def !== 8'd0) begin bad++; $display("FAIL reset_zero_weights_membrane got=%0d exp=0", mem_def); end
    endtask

    task automatic test_single_fire();
        do_reset();
        load_weights(16'hFFFF);
        pre_spike = 4'hF;
        tick();
        pre_spike = 4'h0;
        total++; if (post_def !== 1'b1) begin bad++; $display("FAIL fire_post got=%0d exp=1", post_def); end
        total++; if (mem_def !== 8'd0) begin bad++; $display("FAIL fire_membrane got=%0d exp=0", mem_def); end
        total++; if (cnt_def !== 8'd1) begin bad++; $display("FAIL fire_count got=%0d exp=1", cnt_def); end
        total++; if (st_def !== 2'd1) begin bad++; $display("FAIL fire_state got=%0d exp=1", st_def); end
        tick();
        total++; if (post_def !== 1'b0) begin bad++; $display("FAIL fire_post_width got=%0d exp=0", post_def); end
        total++; if (st_def !== 2'd2) begin bad++; $display("FAIL fire_to_refract got=%0d exp=2", st_def); end
    endtask

    // w0 = 8: 8 -> 7 (leak 1) -> 7 -> 7 (below 2^3 no decay) -> 15.
    task automatic test_leak_floor();
        logic [3:0] pre_tab [5] = '{4'h1, 4'h0, 4'h0, 4'h0, 4'h1};
        logic [7:0] exp_tab [5] = '{8'd8, 8'd7, 8'd7, 8'd7, 8'd15};
        do_reset();
        load_weights(16'h0008);
        for (int i = 0; i < 5; i++) begin
            pre_spike = pre_tab[i];
            tick();
            total++; if (mem_def !== exp_tab[i]) begin bad++; $display("FAIL leak_membrane step=%0d got=%0d exp=%0d", i, mem_def, exp_tab[i]); end
            total++; if (post_def !== 1'b0) begin bad++; $display("FAIL leak_no_spike step=%0d got=%0d exp=0", i, post_def); end
        end
        pre_spike = 4'h0;
    endtask

    // Constant drive: default fires every 5 cycles, REFRACT_CYCLES=0 every 2.
    task automatic test_refractory();
        logic [1:0] st_tab [5] = '{2'd1, 2'd2, 2'd2, 2'd2, 2'd0};
        do_reset();
        load_weights(16'hFFFF);
        pre_spike = 4'hF;
        for (int i = 0; i < 15; i++) begin
            tick();
            total++; if (post_def !== ((i % 5) == 0)) begin bad++; $display("FAIL refr_post cycle=%0d got=%0d exp=%0d", i, post_def, (i % 5) == 0); end
            total++; if (st_def !== st_tab[i % 5]) begin bad++; $display("FAIL refr_state cycle=%0d got=%0d exp=%0d", i, st_def, st_tab[i % 5]); end
            total++; if (mem_def !== 8'd0) begin bad++; $display("FAIL refr_membrane cycle=%0d got=%0d exp=0", i, mem_def); end
            total++; if (post_r0 !== ((i % 2) == 0)) begin bad++; $display("FAIL refr0_post cycle=%0d got=%0d exp=%0d", i, post_r0, (i % 2) == 0); end
        end
        total++; if (cnt_def !== 8'd3) begin bad++; $display("FAIL refr_count got=%0d exp=3", cnt_def); end
        pre_spike = 4'h0;
    endtask

    task automatic test_saturation();
        logic [7:0] mem_tab [6]  = '{8'd60, 8'd113, 8'd159, 8'd200, 8'd235, 8'd0};
        logic       post_tab [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        do_reset();
        load_weights(16'hFFFF);
        pre_spike = 4'hF;
        for (int i = 0; i < 6; i++) begin
            tick();
            total++; if (mem_t255 !== mem_tab[i]) begin bad++; $display("FAIL sat_membrane step=%0d got=%0d exp=%0d", i, mem_t255, mem_tab[i]); end
            total++; if (post_t255 !== post_tab[i]) begin bad++; $display("FAIL sat_post step=%0d got=%0d exp=%0d", i, post_t255, post_tab[i]); end
        end
        // Spike counter: REFRACT_CYCLES=0 fires on ticks 1,3,5,... so after
        // n odd ticks the count is (n+1)/2.
        do_reset();
        load_weights(16'hFFFF);
        pre_spike = 4'hF;
        for (int i = 0; i < 507; i++) tick();
        total++; if (cnt_r0 !== 8'd254) begin bad++; $display("FAIL count_254 got=%0d exp=254", cnt_r0); end
        tick(); tick();
        total++; if (cnt_r0 !== 8'd255) begin bad++; $display("FAIL count_255 got=%0d exp=255", cnt_r0); end
        for (int i = 0; i < 20; i++) tick();
        total++; if (cnt_r0 !== 8'd255) begin bad++; $display("FAIL count_hold got=%0d exp=255", cnt_r0); end
        pre_spike = 4'h0;
    endtask

    // A load on the same edge as a spike integrates with the old weights.
    task automatic test_load_timing();
        do_reset();
        load_weights(16'h0008);
        weight_load = 1'b1; weight_in = 16'h0001; pre_spike = 4'h1;
        tick();
        total++; if (mem_def !== 8'd8) begin bad++; $display("FAIL load_old_weight got=%0d exp=8", mem_def); end
        weight_load = 1'b0; pre_spike = 4'h0;
        tick();
        total++; if (mem_def !== 8'd7) begin bad++; $display("FAIL load_leak got=%0d exp=7", mem_def); end
        pre_spike = 4'h1;
        tick();
        total++; if (mem_def !== 8'd8) begin bad++; $display("FAIL load_new_weight got=%0d exp=8", mem_def); end
        pre_spike = 4'h0;
    endtask

    task automatic test_mid_refract_reset();
        do_reset();
        load_weights(16'hFFFF);
        pre_spike = 4'hF;
        tick();
        tick();
        total++; if (st_def !== 2'd2) begin bad++; $display("FAIL mid_pre_state got=%0d exp=2", st_def); end
        rst_n = 1'b0;
        tick();
        total++; if (st_def !== 2'd0) begin bad++; $display("FAIL mid_reset_state got=%0d exp=0", st_def); end
        total++; if (mem_def !== 8'd0) begin bad++; $display("FAIL mid_reset_membrane got=%0d exp=0", mem_def); end
        total++; if (cnt_def !== 8'd0) begin bad++; $display("FAIL mid_reset_count got=%0d exp=0", cnt_def); end
        total++; if (post_def !== 1'b0) begin bad++; $display("FAIL mid_reset_post got=%0d exp=0", post_def); end
        rst_n = 1'b1; pre_spike = 4'h0;
    endtask

    initial begin
        rst_n = 1'b0; pre_spike = 4'h0; weight_in = 16'h0; weight_load = 1'b0;
        test_reset();
        test_single_fire();
        test_leak_floor();
        test_refractory();
        test_saturation();
        test_load_timing();
        test_mid_refract_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
